// File: rtl/booth_mul_8x8_pkg.sv
// Shared definitions for the sequential Booth multiplier: state encodings,
// add/sub opcodes and the fixed operand width of the add/sub stage.
package booth_mul_8x8_pkg;

  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_8bit.sv
// 8-bit signed add/sub stage: s = a + b (opcode 0) or a - b (opcode 1),
// with a two's-complement overflow flag.
module add_8bit
  import booth_mul_8x8_pkg::*;
(
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  input  logic              opcode,
  output logic signed [7:0] s,
  output logic              is_overflow
);

  always_comb begin
    s           = '0;
    is_overflow = 1'b0;
    if (opcode == OP_SUB) begin
      s           = a - b;
      is_overflow = (a[7] != b[7]) && (s[7] != a[7]);
    end else begin
      s           = a + b;
      is_overflow = (a[7] == b[7]) && (s[7] != a[7]);
    end
  end

endmodule

// File: rtl/booth_mul_8x8.sv
// Sequential radix-2 Booth signed multiplier, 8x8 -> 16, one iteration per cycle.
// Optional macro BOOTH_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module booth_mul_8x8
  import booth_mul_8x8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [7:0]      multiplicand,
  input  logic signed [7:0]      multiplier,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [15:0]     product,
  output logic                   busy
);

  localparam int CNT_W = $clog2(ITER + 1);

  generate
    if (WIDTH != BOOTH_WIDTH) begin : g_width_check
      $error("booth_mul_8x8: WIDTH must be 8 to match the add_8bit stage");
    end
  endgenerate

  state_t                  state, state_nx;
  logic signed [7:0]       acc, qreg, mcand;
  logic                    q_1;
  logic [CNT_W-1:0]        count;

  logic                    do_arith;
  logic                    opcode;
  logic signed [7:0]       sum;
  logic                    ovf;
  logic signed [7:0]       res;
  logic                    sin;
  logic                    accept;
  logic                    zero_op;

  // Sign bit entering the arithmetic shift. After an add/sub the true sign is
  // the 9th result bit, recovered as s[7]^overflow (needed for -128 operands).
  function automatic logic shift_bit(input logic arith, input logic signed [7:0] s,
                                     input logic of, input logic signed [7:0] a);
    return arith ? (s[7] ^ of) : a[7];
  endfunction

  assign do_arith = qreg[0] ^ q_1;
  assign opcode   = ({qreg[0], q_1} == 2'b10) ? OP_SUB : OP_ADD;

  add_8bit u_add (
    .a           (acc),
    .b           (mcand),
    .opcode      (opcode),
    .s           (sum),
    .is_overflow (ovf)
  );

  assign res    = do_arith ? sum : acc;
  assign sin    = shift_bit(do_arith, sum, ovf, acc);
  assign accept = in_valid && in_ready;

`ifdef BOOTH_ZERO_BYPASS_EN
  assign zero_op = (multiplicand == 8'sd0) || (multiplier == 8'sd0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    product   = '0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = zero_op ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (count == CNT_W'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        product   = {acc, qreg};
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shift register {A,Q,Q_1} and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      qreg  <= '0;
      q_1   <= 1'b0;
      mcand <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mcand <= multiplicand;
            acc   <= '0;
            qreg  <= zero_op ? 8'sd0 : multiplier;
            q_1   <= 1'b0;
            count <= CNT_W'(ITER);
          end
        end
        ST_CALC: begin
          acc   <= {sin, res[7:1]};
          qreg  <= {res[0], qreg[7:1]};
          q_1   <= qreg[0];
          count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_8x8.sv
// Scoreboard bench for booth_mul_8x8: directed corner cases, back-pressure,
// mid-operation reset and a randomized sweep against a plain signed multiply.
module tb_booth_mul_8x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
  logic        busy;

  booth_mul_8x8 dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] prod;
    int          due;
  } exp_t;
  exp_t sbq[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [15:0] ref_mul(logic [7:0] a, logic [7:0] b);
    int sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    return p[15:0];
  endfunction

  function automatic int exp_lat(logic [7:0] a, logic [7:0] b);
`ifdef BOOTH_ZERO_BYPASS_EN
    if (a == 8'h00 || b == 8'h00) return 1;
`endif
    return 9;
  endfunction

  // out_ready policy: 0 = always ready, 1 = random, 2 = stalled
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compares every presented output against the scoreboard head.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          if (!ov_prev) check("latency", cyc, sbq[0].due);
          check("product", product, sbq[0].prod);
          check("ready_busy_in_done", {in_ready, busy}, 2'b01);
          if (out_ready) sbq.delete(0);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int g;
    g = 0;
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    do begin
      @(negedge clk);
      g++;
    end while (!in_ready && g < 200);
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    else sbq.push_back('{ref_mul(a, b), cyc + exp_lat(a, b)});
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 400) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (sbq.size() != 0) check("drain_timeout", sbq.size(), 32'd0);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [7:0] a, b;
    rst          = 1'b1;
    in_valid     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {in_ready, out_valid, busy, product}, {1'b1, 1'b0, 1'b0, 16'h0000});
    sync();

    // 3*5 with in_ready returning the cycle after the handshake
    send(8'd3, 8'd5);
    wait_idle();
    @(negedge clk);
    check("in_ready_after_done", in_ready, 32'd1);
    sync();

    send(8'h80, 8'h80);
    send(8'hF9, 8'h06);
    send(8'h7F, 8'h80);
    send(8'h80, 8'h7F);
    send(8'hFF, 8'hFF);
    send(8'h80, 8'h01);
    send(8'h00, 8'hFB);
    send(8'h2A, 8'h00);
    wait_idle();
    sync();

    // Back-pressure: output held, second in_valid ignored
    rdy_mode = 2;
    sync();
    send(8'h15, 8'hE3);
    g = 0;
    while (!out_valid && g < 30) begin
      @(negedge clk);
      g++;
    end
    check("bp_out_valid_seen", out_valid, 32'd1);
    for (int i = 0; i < 5; i++) begin
      sync();
      in_valid     = (i == 2);
      multiplicand = 8'h11;
      multiplier   = 8'h22;
      @(negedge clk);
      check("bp_valid_held", out_valid, 32'd1);
    end
    sync();
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();
    @(negedge clk);
    @(negedge clk);
    check("bp_pulse_ignored", {busy, out_valid, in_ready}, 3'b001);
    sync();

    // Reset during CALC iteration 4
    in_valid     = 1'b1;
    multiplicand = 8'd3;
    multiplier   = 8'd7;
    @(negedge clk);
    sync();
    in_valid = 1'b0;
    repeat (3) sync();
    check("busy_in_calc", {busy, in_ready}, 2'b10);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_state", {in_ready, out_valid, busy, product}, {1'b1, 1'b0, 1'b0, 16'h0000});
    sync();
    send(8'd2, 8'd2);
    wait_idle();
    sync();

    // Randomized sweep with random out_ready
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      a = pick();
      b = pick();
      send(a, b);
    end
    wait_idle();
    rdy_mode = 0;
    repeat (2) sync();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
